// File: rtl/fir_mac_filter_pkg.sv
// Shared types, sizes and helpers for the time-multiplexed FIR filter.
//   Types: sample_t, coef_t, prod_t, acc_t, state_e.
//   Sizes: NTAPS, DW, ACCW, FRAC and the derived index widths.
//   saturate(): converts the accumulator to an output sample (shift by FRAC, then clamp).
package fir_mac_filter_pkg;

  localparam int unsigned NTAPS = 128;
  localparam int unsigned DW    = 16;
  localparam int unsigned ACCW  = 40;
  localparam int unsigned FRAC  = 15;

  // Tap index / delay-line address width and fill-count width (must reach NTAPS).
  localparam int unsigned KW    = $clog2(NTAPS);
  localparam int unsigned FILLW = $clog2(NTAPS + 1);

  typedef logic signed [DW-1:0]   sample_t;
  typedef logic signed [DW-1:0]   coef_t;
  typedef logic signed [2*DW-1:0] prod_t;
  typedef logic signed [ACCW-1:0] acc_t;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    FLUSH,
    DONE
  } state_e;

  localparam sample_t SAT_MAX = 16'h7FFF;
  localparam sample_t SAT_MIN = 16'h8000;

  // Arithmetic shift floors toward minus infinity, then clamp to the sample range.
  function automatic sample_t saturate(input acc_t acc);
    acc_t    shifted;
    sample_t res;
    shifted = acc >>> FRAC;
    if (shifted > acc_t'(SAT_MAX)) begin
      res = SAT_MAX;
    end else if (shifted < acc_t'(SAT_MIN)) begin
      res = SAT_MIN;
    end else begin
      res = sample_t'(shifted);
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_mac_filter_if.sv
// Sample stream interface of the FIR filter.
//   in_sample / in_valid / in_ready : upstream sample handshake
//   out_sample / out_valid          : filtered result, out_valid is a one-cycle pulse
//   master: upstream/downstream side; slave: the filter.
interface fir_mac_filter_if;
  import fir_mac_filter_pkg::*;

  sample_t in_sample;
  logic    in_valid;
  logic    in_ready;
  sample_t out_sample;
  logic    out_valid;

  modport master (
    output in_sample,
    output in_valid,
    input  in_ready,
    input  out_sample,
    input  out_valid
  );

  modport slave (
    input  in_sample,
    input  in_valid,
    output in_ready,
    output out_sample,
    output out_valid
  );

endinterface

// File: rtl/fir_delay_line.sv
// Circular sample history for the FIR filter.
//   clk, reset : clock, synchronous active-high reset (clears pointer and fill count)
//   wr_en, din : write din at the current write pointer; fill count saturates at NTAPS
//   advance    : step the write pointer (wraps NTAPS-1 -> 0)
//   rd_k       : tap offset; rd_data_c = x[n-k], or zero when k >= fill count
// Storage has no reset so it can map onto RAM; stale history is hidden by the fill count.
module fir_delay_line
  import fir_mac_filter_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  sample_t         din,
  input  logic            advance,
  input  logic [KW-1:0]   rd_k,
  output sample_t         rd_data_c
);

  sample_t          mem [NTAPS];
  logic [KW-1:0]    ptr;
  logic [FILLW-1:0] fill;
  logic [KW-1:0]    rd_addr_c;

  // Sample storage.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[ptr] <= din;
    end
  end

  // Write pointer and fill count.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr  <= '0;
      fill <= '0;
    end else begin
      if (wr_en && (fill != FILLW'(NTAPS))) begin
        fill <= fill + 1'b1;
      end
      if (advance) begin
        ptr <= (ptr == KW'(NTAPS - 1)) ? '0 : ptr + 1'b1;
      end
    end
  end

  // Read address (ptr - k) mod NTAPS, and masking of entries not yet written since reset.
  always_comb begin
    rd_addr_c = '0;
    rd_data_c = '0;
    if (ptr >= rd_k) begin
      rd_addr_c = ptr - rd_k;
    end else begin
      rd_addr_c = KW'(int'(NTAPS) + int'(ptr) - int'(rd_k));
    end
    if (FILLW'(rd_k) < fill) begin
      rd_data_c = mem[rd_addr_c];
    end
  end

endmodule

// File: rtl/fir_mac_filter.sv
// Time-multiplexed FIR filter: one multiplier-accumulator, one output per accepted sample.
//   clk, reset : clock, synchronous active-high reset
//   allTaps    : packed coefficients, tap k = allTaps[DW*k +: DW], signed Q1.15, read live
//   bus        : sample stream (in_sample/in_valid/in_ready, out_sample/out_valid)
// An accepted sample produces out_valid NTAPS+2 edges later; in_ready is low meanwhile.
module fir_mac_filter
  import fir_mac_filter_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [NTAPS*DW-1:0] allTaps,
  fir_mac_filter_if.slave     bus
);

  state_e        state;
  logic [KW-1:0] k;
  prod_t         prod;
  acc_t          acc;
  logic          ready_q;
  logic          ovalid_q;
  sample_t       osample_q;

  coef_t         taps [NTAPS];
  sample_t       x_c;
  logic          accept_c;
  logic          advance_c;

  // Unpack the coefficient vector; taps are read directly each MAC cycle.
  for (genvar g = 0; g < NTAPS; g++) begin : g_tap
    assign taps[g] = allTaps[DW*g +: DW];
  end

  assign accept_c  = (state == IDLE) && bus.in_valid;
  assign advance_c = (state == DONE);

  fir_delay_line u_delay_line (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (accept_c),
    .din       (bus.in_sample),
    .advance   (advance_c),
    .rd_k      (k),
    .rd_data_c (x_c)
  );

  // Control FSM and datapath. The product register lags the tap index by one cycle,
  // so the accumulator adds product k-1 while product k is formed; FLUSH adds the last.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      k         <= '0;
      prod      <= '0;
      acc       <= '0;
      ready_q   <= 1'b1;
      ovalid_q  <= 1'b0;
      osample_q <= '0;
    end else begin
      ovalid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            state   <= MAC;
            k       <= '0;
            prod    <= '0;
            acc     <= '0;
            ready_q <= 1'b0;
          end
        end
        MAC: begin
          prod <= prod_t'(x_c) * prod_t'(taps[k]);
          acc  <= acc + acc_t'(prod);
          if (k == KW'(NTAPS - 1)) begin
            state <= FLUSH;
          end else begin
            k <= k + 1'b1;
          end
        end
        FLUSH: begin
          acc   <= acc + acc_t'(prod);
          state <= DONE;
        end
        DONE: begin
          osample_q <= saturate(acc);
          ovalid_q  <= 1'b1;
          ready_q   <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready   = ready_q;
  assign bus.out_valid  = ovalid_q;
  assign bus.out_sample = osample_q;

endmodule

// File: tb/tb_fir_mac_filter.sv
// Self-checking bench for fir_mac_filter: directed impulse/DC/saturation/reset/tap-update
// cases plus randomized back-to-back traffic, compared against a sum-of-products model.
module tb_fir_mac_filter;
  import fir_mac_filter_pkg::*;

  localparam int LIMIT = 1000;
  localparam int LAT   = NTAPS + 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [NTAPS*DW-1:0] all_taps;
  sample_t             hist [$];
  int                  n_tests = 0;
  int                  n_fail  = 0;

  fir_mac_filter_if bus ();

  fir_mac_filter dut (
    .clk     (clk),
    .reset   (reset),
    .allTaps (all_taps),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic sample_t tap_val(input int k);
    return all_taps[DW*k +: DW];
  endfunction

  function automatic void set_all_taps(input sample_t v);
    for (int k = 0; k < NTAPS; k++) all_taps[DW*k +: DW] = v;
  endfunction

  // y[n] = clamp(floor(sum_k h[k]*x[n-k] / 2^FRAC)) over samples accepted since reset.
  function automatic longint model_out();
    longint acc;
    int     n;
    acc = 0;
    n   = hist.size();
    for (int k = 0; k < NTAPS && k < n; k++)
      acc += longint'(tap_val(k)) * longint'(hist[n-1-k]);
    acc = acc >>> FRAC;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return acc;
  endfunction

  // Time invariant on entry/exit: 1 time unit after a rising edge.
  task automatic push(input sample_t s, input bit hold, output sample_t got);
    int     n;
    int     lat;
    int     bad_ready;
    longint exp;
    bus.in_sample = s;
    bus.in_valid  = 1'b1;
    n = 0;
    while (!bus.in_ready && n < LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_wait", n, 0);
    @(posedge clk); #1;
    if (hold) bus.in_sample = sample_t'($urandom);
    else      bus.in_valid  = 1'b0;
    hist.push_back(s);
    exp = model_out();
    check("ready_drop", bus.in_ready, 0);
    lat       = 0;
    bad_ready = 0;
    while (!bus.out_valid && lat < LIMIT) begin
      if (bus.in_ready) bad_ready++;
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, LAT);
    check("ready_low", bad_ready, 0);
    check("ready_back", bus.in_ready, 1);
    check("out_sample", bus.out_sample, exp);
    got = bus.out_sample;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    hist.delete();
  endtask

  initial begin
    sample_t got;
    int      seen;

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sample = '0;
    all_taps      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_sample", bus.out_sample, 0);
    reset = 1'b0;

    // Impulse response.
    set_all_taps('0);
    all_taps[15:0]  = 16'h4000;
    all_taps[31:16] = 16'h2000;
    push(16'h7FFF, 1'b0, got);
    check("imp_0", got, 16'h3FFF);
    @(posedge clk); #1;
    check("pulse_width", bus.out_valid, 0);
    check("out_hold", bus.out_sample, 16'h3FFF);
    push(16'h0000, 1'b0, got);
    check("imp_1", got, 16'h1FFF);
    push(16'h0000, 1'b0, got);
    check("imp_2", got, 0);
    push(16'h0000, 1'b0, got);
    check("imp_3", got, 0);

    // DC ramp through pointer wrap.
    do_reset();
    set_all_taps(16'h0100);
    for (int i = 0; i < 200; i++) begin
      push(16'h1000, 1'b0, got);
      check("dc_ramp", got, (i + 1) * 32 > 4096 ? 4096 : (i + 1) * 32);
      if (i == 0) check("dc_first", got, 16'h0020);
    end
    check("dc_steady", got, 16'h1000);

    // Positive and negative saturation.
    do_reset();
    set_all_taps(16'h7FFF);
    for (int i = 0; i < NTAPS; i++) push(16'h7FFF, 1'b0, got);
    check("sat_pos", got, SAT_MAX);
    do_reset();
    for (int i = 0; i < NTAPS; i++) push(SAT_MIN, 1'b0, got);
    check("sat_neg", got, SAT_MIN);

    // Randomized back-to-back traffic with in_valid held high.
    do_reset();
    for (int k = 0; k < NTAPS; k++)
      all_taps[DW*k +: DW] = 16'($urandom_range(0, 4095)) - 16'd2048;
    for (int i = 0; i < 30; i++) push(sample_t'($urandom), 1'b1, got);
    bus.in_valid = 1'b0;

    // Reset in the middle of a computation discards it and the history.
    do_reset();
    set_all_taps('0);
    all_taps[15:0]  = 16'h4000;
    all_taps[31:16] = 16'h2000;
    for (int i = 0; i < 3; i++) push(sample_t'($urandom_range(1000, 30000)), 1'b0, got);
    bus.in_sample = 16'h7FFF;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("abort_accepted", bus.in_ready, 0);
    seen = 0;
    repeat (50) begin
      if (bus.out_valid) seen++;
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    hist.delete();
    repeat (LAT + 10) begin
      if (bus.out_valid) seen++;
      @(posedge clk); #1;
    end
    check("abort_no_valid", seen, 0);
    check("abort_ready", bus.in_ready, 1);
    push(16'h7FFF, 1'b0, got);
    check("post_rst_0", got, 16'h3FFF);
    push(16'h0000, 1'b0, got);
    check("post_rst_1", got, 16'h1FFF);

    // Coefficient change while idle takes effect on the next sample.
    do_reset();
    all_taps[15:0] = 16'h7FFF;
    push(16'h4000, 1'b0, got);
    check("tap_update", got, 16'h3FFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
